// File: rtl/bcd_frame_conv_if.sv
// ============================================================================
// Module      : bcd_frame_conv_if
// Description : Request/result bundle between a frame source and bcd_frame_conv.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_frame_conv_if #(
    parameter int L      = 47,
    parameter int IN_W   = 10,
    parameter int DIGITS = 4
);
    logic                     start;
    logic [L*IN_W-1:0]        bin;
    logic                     busy;
    logic                     done;
    logic [L*DIGITS*4-1:0]    dec;

    modport master (output start, bin, input busy, done, dec);
    modport slave  (input start, bin, output busy, done, dec);
endinterface

`default_nettype wire

// File: rtl/bcd_frame_conv.sv
// ============================================================================
// Module      : bcd_frame_conv
// Description : Frame-atomic multi-word binary-to-BCD converter (double dabble).
//               Optional leading-zero blanking when BCD_LZ_BLANK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_frame_conv #(
    parameter int L      = 47,
    parameter int IN_W   = 10,
    parameter int DIGITS = 4
) (
    input  wire logic          clk,
    input  wire logic          RSTn,
    bcd_frame_conv_if.slave    bus
);
    localparam int BCD_W = DIGITS * 4;
    localparam int SR_W  = BCD_W + IN_W;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int IDX_W = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        STORE = 2'd3
    } state_t;

    state_t               state;
    logic [L*IN_W-1:0]    snap;
    logic [L*BCD_W-1:0]   work;
    logic [SR_W-1:0]      sreg;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;

    logic [SR_W-1:0]      adj;
    logic [BCD_W-1:0]     raw;
    logic [BCD_W-1:0]     digits;
    logic [L*BCD_W-1:0]   work_next;
`ifdef BCD_LZ_BLANK_EN
    logic                 lead;
`endif

    // Add-3 correction on every BCD nibble sitting above the binary field
    always_comb begin
        adj = sreg;
        for (int d = 0; d < DIGITS; d++) begin
            if (sreg[IN_W + d*4 +: 4] >= 4'd5)
                adj[IN_W + d*4 +: 4] = sreg[IN_W + d*4 +: 4] + 4'd3;
        end
    end

    always_comb begin
        raw    = sreg[SR_W-1 -: BCD_W];
        digits = raw;
`ifdef BCD_LZ_BLANK_EN
        lead   = 1'b1;
        // Least-significant digit is never blanked so zero still shows as "0"
        for (int d = DIGITS - 1; d > 0; d--) begin
            if (lead && (raw[d*4 +: 4] == 4'd0))
                digits[d*4 +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
`endif
    end

    always_comb begin
        work_next = work;
        work_next[idx*BCD_W +: BCD_W] = digits;
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state    <= IDLE;
            snap     <= '0;
            work     <= '0;
            sreg     <= '0;
            cnt      <= '0;
            idx      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.dec  <= '1;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        snap     <= bus.bin;
                        idx      <= IDX_W'(L - 1);
                        work     <= '0;
                        bus.busy <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    sreg  <= {{BCD_W{1'b0}}, snap[idx*IN_W +: IN_W]};
                    cnt   <= CNT_W'(IN_W);
                    state <= SHIFT;
                end
                SHIFT: begin
                    sreg <= {adj[SR_W-2:0], 1'b0};
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state <= STORE;
                end
                STORE: begin
                    work <= work_next;
                    if (idx != '0) begin
                        idx   <= idx - 1'b1;
                        state <= LOAD;
                    end else begin
                        // Whole frame published on one edge: no tearing
                        bus.dec  <= work_next;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire
